ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
- AHB slave with zero-wait-state word-addressed SRAM, accepting single and burst transfers from one master.
- Sits behind the bus decoder; the system ties hsel high for this slave.
- Signals illegal accesses with the standard two-cycle ERROR response and a sideband error flag.
- Pipelined address/data phases per AMBA AHB.

Parameters:
- ADDR_WIDTH, 32, haddr width.
- DATA_WIDTH, 32, hwdata/hrdata width; byte lanes little-endian.
- MEM_DEPTH, 256, number of DATA_WIDTH words; legal byte range is 0 to MEM_DEPTH*4-1.

Ports:
- hclk  in  1  clock; all logic on rising edge.
- hresetn  in  1  reset, synchronous, active-low.
- hsel  in  1  slave select.
- haddr  in  ADDR_WIDTH  byte address.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1=write, 0=read.
- hsize  in  3  000 byte, 001 halfword, 010 word; others illegal.
- hburst  in  3  burst type; accepted, no effect (master supplies every address).
- hprot  in  4  protection; ignored.
- hwdata  in  DATA_WIDTH  write data (data phase).
- hrdata  out  DATA_WIDTH  read data (data phase).
- hready  out  1  transfer done / slave ready.
- hresp  out  2  OKAY=00, ERROR=01.
- error  out  1  high in both cycles of an ERROR response.

Behaviour:
- Reset (hresetn=0 at a clock edge):
  - hready=1, hresp=OKAY, hrdata=0, error=0.
  - Pending data phase discarded.
  - Memory contents not cleared.
- Address-phase sampling:
  - Occurs on an edge where hready=1, hsel=1 and htrans is NONSEQ or SEQ.
  - Registers haddr, hwrite, hsize and a valid bit for the data phase in the next cycle.
  - IDLE/BUSY, or hsel=0, set valid=0: zero-wait OKAY, no memory access.
- Legality check at address phase. Illegal if any of:
  - haddr >= MEM_DEPTH*4;
  - hsize > 010;
  - halfword with haddr[0]=1;
  - word with haddr[1:0]!=00.
- Legal write:
  - Data phase is one cycle with hready=1, hresp=OKAY.
  - On the closing edge, the byte lanes selected by hsize and addr[1:0] are written from the matching hwdata lanes.
  - Other bytes are unchanged.
- Legal read:
  - Data phase is one cycle with hready=1, hresp=OKAY.
  - hrdata = full memory word at addr[ADDR_WIDTH-1:2], combinational from the registered address; all lanes driven.
  - hrdata = 0 when no read data phase is active.
- Illegal transfer, two-cycle ERROR:
  - Cycle 1: hready=0, hresp=ERROR, error=1.
  - Cycle 2: hready=1, hresp=ERROR, error=1.
  - Memory never modified.
  - Address-phase signals presented during cycle 1 are ignored.
  - Those presented in cycle 2 are sampled normally (master may cancel with IDLE).
- Back-to-back: write to A then read of A in the next cycle returns the new data. This holds because the write commits at the edge ending its data phase and the read data phase follows.
- Bursts: SEQ beats handled identically to NONSEQ.
  - No wrap/increment computed internally.
  - An out-of-range beat inside a burst errors on that beat only.
- Reset asserted mid-transfer or mid-ERROR: outputs return to reset values on that edge; the interrupted write is not committed.
- hready is low only in ERROR cycle 1; no other wait states.

Decomposition:
- Package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, HSIZE_BYTE/HALF/WORD constants;
  - typedefs htrans_t, hresp_t, hsize_t;
  - helper function computing byte-enable from hsize and addr[1:0].
- One sub-module, ahb_slave_ram: single-port word memory with byte-enable write and asynchronous read.
- Top holds the address-phase register, legality check and ERROR FSM.
- FSM states: IDLE_OK, ERR1, ERR2.

Test Plan:
- Reset then IDLE: hresetn low 1 cycle, htrans=IDLE → hready=1, hresp=00, hrdata=0, error=0.
- Word write/read: write 0xDEADBEEF to 0x10, read 0x10 next cycle → hrdata=0xDEADBEEF, hresp=00, zero waits.
- Byte/halfword writes: word 0x0 = 0x11223344; byte write 0xAA at 0x1; half write 0x5566 at 0x2 → read 0x0 returns 0x5566AA44.
- INCR4 burst: NONSEQ 0x20, SEQ 0x24/0x28/0x2C writing 1,2,3,4 → reads return 1,2,3,4, hready held 1.
- Out-of-range error: write to 0x400 (MEM_DEPTH=256) → cycle 1 hready=0/hresp=01/error=1, cycle 2 hready=1/hresp=01; memory unchanged.
- Unaligned/illegal size: word read at 0x6, then hsize=011 → ERROR each; a following legal read at 0x10 returns OKAY with correct data.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the byte-lane enable helper for the slave memory.
package ahb_pkg;

  typedef logic [1:0] htrans_t;
  typedef logic [1:0] hresp_t;
  typedef logic [2:0] hsize_t;

  localparam htrans_t HTRANS_IDLE   = 2'b00;
  localparam htrans_t HTRANS_BUSY   = 2'b01;
  localparam htrans_t HTRANS_NONSEQ = 2'b10;
  localparam htrans_t HTRANS_SEQ    = 2'b11;

  localparam hresp_t HRESP_OKAY  = 2'b00;
  localparam hresp_t HRESP_ERROR = 2'b01;

  localparam hsize_t HSIZE_BYTE = 3'b000;
  localparam hsize_t HSIZE_HALF = 3'b001;
  localparam hsize_t HSIZE_WORD = 3'b010;

  localparam int unsigned BE_W = 4;

  // Little-endian lane select for a transfer of the given size at addr[1:0].
  function automatic logic [BE_W-1:0] byte_en(input hsize_t size, input logic [1:0] addr);
    logic [BE_W-1:0] be;
    be = '0;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Single-port word memory, byte-enable write on the rising edge, asynchronous read.
module ahb_slave_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [STRB_W-1:0]     i_be,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // One array per byte lane keeps every lane's storage owned by a single process.
  for (genvar g = 0; g < STRB_W; g++) begin : g_lane
    logic [7:0] r_lane [DEPTH];

    always_ff @(posedge clk) begin
      if (i_we && i_be[g]) begin
        r_lane[i_addr] <= i_wdata[g*8 +: 8];
      end
    end

    assign o_rdata[g*8 +: 8] = r_lane[i_addr];
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// Zero-wait AHB slave SRAM: address-phase register, legality check and two-cycle ERROR FSM.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic [1:0]            hresp,
  output logic                  error
);

  localparam int unsigned MEM_BYTES = MEM_DEPTH * 4;
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  localparam int unsigned STRB_W    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE_OK, ERR1, ERR2} state_t;

  state_t                r_state;
  logic                  r_valid;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  hsize_t                r_size;
  logic                  r_hready;
  hresp_t                r_hresp;
  logic                  r_error;

  logic                  w_active;
  logic                  w_legal;
  logic                  w_we;
  logic [STRB_W-1:0]     w_be;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  assign w_active = hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign w_legal  = (haddr < ADDR_WIDTH'(MEM_BYTES))
                 && (hsize <= HSIZE_WORD)
                 && !(hsize == HSIZE_HALF && haddr[0])
                 && !(hsize == HSIZE_WORD && haddr[1:0] != 2'b00);

  // ERR1 holds hready low, so address-phase inputs are only taken in IDLE_OK and ERR2.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state  <= IDLE_OK;
      r_valid  <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_size   <= HSIZE_BYTE;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        ERR1: begin
          r_state  <= ERR2;
          r_hready <= 1'b1;
        end
        default: begin
          r_state  <= IDLE_OK;
          r_valid  <= 1'b0;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_OKAY;
          r_error  <= 1'b0;
          if (w_active) begin
            r_addr  <= haddr;
            r_write <= hwrite;
            r_size  <= hsize;
            if (w_legal) begin
              r_valid <= 1'b1;
            end else begin
              r_state  <= ERR1;
              r_hready <= 1'b0;
              r_hresp  <= HRESP_ERROR;
              r_error  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // A reset on the closing edge drops the pending write.
  assign w_we = r_valid && r_write && hresetn;
  assign w_be = STRB_W'(byte_en(r_size, r_addr[1:0]));

  ahb_slave_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .IDX_W      (IDX_W),
    .STRB_W     (STRB_W)
  ) u_ram (
    .clk     (hclk),
    .i_we    (w_we),
    .i_addr  (r_addr[IDX_W+1:2]),
    .i_be    (w_be),
    .i_wdata (hwdata),
    .o_rdata (w_rdata)
  );

  assign hrdata = (r_valid && !r_write) ? w_rdata : '0;
  assign hready = r_hready;
  assign hresp  = r_hresp;
  assign error  = r_error;

  assign w_unused = &{1'b0, hburst, hprot, r_addr[ADDR_WIDTH-1:IDX_W+2]};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed stimulus with a cycle-tagged expectation queue drained by a separate monitor.
module tb_ahb_slave_mem;

  logic        hclk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;
  logic        error;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SQ   = 2'b11;
  localparam logic [2:0] S_B    = 3'b000;
  localparam logic [2:0] S_H    = 3'b001;
  localparam logic [2:0] S_W    = 3'b010;
  localparam int K_OK   = 0;
  localparam int K_ERR  = 1;
  localparam int K_NONE = 2;
  localparam int K_ERR1 = 3;

  typedef struct {
    int unsigned cyc;
    logic        rdy;
    logic [1:0]  resp;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pend_wd = '0;

  ahb_slave_mem dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .hsel    (hsel),
    .haddr   (haddr),
    .htrans  (htrans),
    .hwrite  (hwrite),
    .hsize   (hsize),
    .hburst  (hburst),
    .hprot   (hprot),
    .hwdata  (hwdata),
    .hrdata  (hrdata),
    .hready  (hready),
    .hresp   (hresp),
    .error   (error)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial forever begin
    @(posedge hclk);
    cyc = cyc + 1;
  end

  task automatic push(input int unsigned c, input logic r, input logic [1:0] rs,
                      input logic er, input logic [31:0] d);
    exp_t x;
    x.cyc = c; x.rdy = r; x.resp = rs; x.err = er; x.rd = d;
    q.push_back(x);
  endtask

  // Drive one address phase; hwdata carries the previous transfer's write data.
  task automatic issue(input logic rst, input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input int kind, input logic [31:0] exp_rd);
    @(posedge hclk);
    #1;
    hresetn = rst;
    hsel    = sel;
    htrans  = tr;
    hwrite  = wr;
    hsize   = sz;
    haddr   = a;
    hburst  = (tr == T_NS || tr == T_SQ) ? 3'b011 : 3'b000;
    hwdata  = pend_wd;
    pend_wd = wd;
    case (kind)
      K_OK:   push(cyc + 1, 1'b1, 2'b00, 1'b0, exp_rd);
      K_ERR: begin
        push(cyc + 1, 1'b0, 2'b01, 1'b1, 32'h0);
        push(cyc + 2, 1'b1, 2'b01, 1'b1, 32'h0);
      end
      K_ERR1: push(cyc + 1, 1'b0, 2'b01, 1'b1, 32'h0);
      default: ;
    endcase
  endtask

  task automatic wr(input logic [1:0] tr, input logic [2:0] sz, input logic [31:0] a,
                    input logic [31:0] d);
    issue(1'b1, 1'b1, tr, 1'b1, sz, a, d, K_OK, 32'h0);
  endtask

  task automatic rd(input logic [1:0] tr, input logic [31:0] a, input logic [31:0] x);
    issue(1'b1, 1'b1, tr, 1'b0, S_W, a, 32'h0, K_OK, x);
  endtask

  task automatic idle();
    issue(1'b1, 1'b1, T_IDLE, 1'b0, S_W, 32'h0, 32'h0, K_OK, 32'h0);
  endtask

  task automatic hold();
    issue(1'b1, 1'b1, T_IDLE, 1'b0, S_W, 32'h0, 32'h0, K_NONE, 32'h0);
  endtask

  task automatic bad(input logic w, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] d);
    issue(1'b1, 1'b1, T_NS, w, sz, a, d, K_ERR, 32'h0);
  endtask

  // Monitor: compare every cycle that has a queued expectation.
  initial forever begin
    @(negedge hclk);
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks = checks + 1;
      if (e.cyc != cyc) begin
        errors = errors + 1;
        $display("FAIL missed_cycle: expected entry for cycle %0d seen at cycle %0d", e.cyc, cyc);
      end else if ({hready, hresp, error, hrdata} !== {e.rdy, e.resp, e.err, e.rd}) begin
        errors = errors + 1;
        $display("FAIL resp cyc=%0d: got hready=%b hresp=%b error=%b hrdata=%h, want hready=%b hresp=%b error=%b hrdata=%h",
                 cyc, hready, hresp, error, hrdata, e.rdy, e.resp, e.err, e.rd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
    $fatal(1);
  end

  initial begin
    hresetn = 1'b0; hsel = 1'b1; htrans = T_IDLE; hwrite = 1'b0; hsize = S_W;
    haddr = '0; hburst = '0; hprot = 4'b0011; hwdata = '0;
    repeat (2) @(posedge hclk);

    // Reset state followed by IDLE.
    issue(1'b0, 1'b1, T_IDLE, 1'b0, S_W, 32'h0, 32'h0, K_OK, 32'h0);

    // Word write then immediate read-back.
    wr(T_NS, S_W, 32'h10, 32'hDEADBEEF);
    rd(T_NS, 32'h10, 32'hDEADBEEF);

    // Byte and halfword lane merging.
    wr(T_NS, S_W, 32'h0, 32'h11223344);
    wr(T_NS, S_B, 32'h1, 32'h5A5AAA5A);
    wr(T_NS, S_H, 32'h2, 32'h5566A5A5);
    rd(T_NS, 32'h0, 32'h5566AA44);

    // INCR4 burst with a BUSY beat, then read back.
    wr(T_NS, S_W, 32'h20, 32'd1);
    wr(T_SQ, S_W, 32'h24, 32'd2);
    issue(1'b1, 1'b1, T_BUSY, 1'b1, S_W, 32'h28, 32'h0, K_OK, 32'h0);
    wr(T_SQ, S_W, 32'h28, 32'd3);
    wr(T_SQ, S_W, 32'h2C, 32'd4);
    rd(T_NS, 32'h20, 32'd1);
    rd(T_SQ, 32'h24, 32'd2);
    rd(T_SQ, 32'h28, 32'd3);
    rd(T_SQ, 32'h2C, 32'd4);

    // Last legal byte.
    wr(T_NS, S_W, 32'h3FC, 32'h0);
    wr(T_NS, S_B, 32'h3FF, 32'h77A5A5A5);
    rd(T_NS, 32'h3FC, 32'h77000000);

    // Out of range write; a read offered during ERR1 must be ignored.
    bad(1'b1, S_W, 32'h400, 32'hBADBAD00);
    issue(1'b1, 1'b1, T_NS, 1'b0, S_W, 32'h10, 32'h0, K_NONE, 32'h0);
    idle();
    rd(T_NS, 32'h0, 32'h5566AA44);

    // Misaligned word, bad size, misaligned half; each next one sampled in ERR2.
    bad(1'b0, S_W, 32'h6, 32'h0);
    hold();
    bad(1'b0, 3'b011, 32'h10, 32'h0);
    hold();
    bad(1'b1, S_H, 32'h11, 32'hFFFFFFFF);
    hold();
    rd(T_NS, 32'h10, 32'hDEADBEEF);

    // Deselected write has no effect.
    issue(1'b1, 1'b0, T_NS, 1'b1, S_W, 32'h10, 32'h0, K_OK, 32'h0);
    rd(T_NS, 32'h10, 32'hDEADBEEF);

    // Reset during a write data phase: write not committed.
    wr(T_NS, S_W, 32'h30, 32'hAAAAAAAA);
    wr(T_NS, S_W, 32'h30, 32'h12345678);
    issue(1'b0, 1'b1, T_IDLE, 1'b0, S_W, 32'h0, 32'h0, K_OK, 32'h0);
    rd(T_NS, 32'h30, 32'hAAAAAAAA);

    // Reset during ERR1: returns to reset values instead of ERR2.
    issue(1'b1, 1'b1, T_NS, 1'b1, S_W, 32'h31, 32'h0, K_ERR1, 32'h0);
    issue(1'b0, 1'b1, T_IDLE, 1'b0, S_W, 32'h0, 32'h0, K_OK, 32'h0);
    rd(T_NS, 32'h30, 32'hAAAAAAAA);
    idle();
    idle();

    repeat (3) @(posedge hclk);
    @(negedge hclk);
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
